// File: rtl/flag_pkg.sv
// Shared encodings for the execute-stage flag controller: opcode classes,
// flag bit positions and controller FSM states.
package flag_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_ALU  = 3'd1,
      OP_SETC = 3'd2,
      OP_CLRC = 3'd3,
      OP_JZ   = 3'd4,
      OP_JN   = 3'd5,
      OP_JC   = 3'd6,
      OP_RSVD = 3'd7
   } ex_op_e;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;

   typedef enum logic {
      IDLE    = 1'b0,
      RESTORE = 1'b1
   } state_e;

endpackage

// File: rtl/flag_shadow_stack.sv
// LIFO holding flag snapshots across interrupt entry; overflow, underflow or
// an external error request set a sticky error bit cleared only by reset.
module flag_shadow_stack #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             err_set,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top_data,
   output logic             full,
   output logic             empty,
   output logic             err
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = AW + 1;

   logic [SW-1:0]             sp;
   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic                      do_push;
   logic                      do_pop;

   assign full     = (sp == SW'(DEPTH));
   assign empty    = (sp == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   // Entry below sp; meaningless when empty, callers gate on empty.
   assign top_data = mem[AW'(sp - SW'(1))];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp  <= '0;
         err <= 1'b0;
      end else begin
         if (do_push)
            sp <= sp + SW'(1);
         else if (do_pop)
            sp <= sp - SW'(1);
         if ((push && full) || (pop && empty) || err_set)
            err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[sp[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/flag_ctrl_unit.sv
// Merges ALU, SETC/CLRC and taken-jump flag updates into one flag-register
// write, and saves/restores flags through a shadow stack around interrupts.
module flag_ctrl_unit
   import flag_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       ex_op,
   input  logic [WIDTH-1:0] alu_flags,
   input  logic [WIDTH-1:0] alu_mask,
   input  logic [WIDTH-1:0] flags_in,
   input  logic             int_save,
   input  logic             int_restore,
   output logic [WIDTH-1:0] flag_wdata,
   output logic             flag_we,
   output logic             jmp_taken,
   output logic             stall,
   output logic             stack_full,
   output logic             stack_empty,
   output logic             stack_err
);

   state_e           state, state_nxt;
   logic [WIDTH-1:0] next_flags;
   logic             merge_we;
   logic             jmp;
   logic             push, pop, err_set;
   logic [WIDTH-1:0] top_data;

   always_comb begin
      next_flags = flags_in;
      merge_we   = 1'b0;
      jmp        = 1'b0;
      case (ex_op_e'(ex_op))
         OP_ALU: begin
            next_flags = (flags_in & ~alu_mask) | (alu_flags & alu_mask);
            merge_we   = |alu_mask;
         end
         OP_SETC: begin
            next_flags[FLAG_C] = 1'b1;
            merge_we           = 1'b1;
         end
         OP_CLRC: begin
            next_flags[FLAG_C] = 1'b0;
            merge_we           = 1'b1;
         end
         OP_JZ: begin
            jmp                = flags_in[FLAG_Z];
            next_flags[FLAG_Z] = 1'b0;
            merge_we           = jmp;
         end
         OP_JN: begin
            jmp                = flags_in[FLAG_N];
            next_flags[FLAG_N] = 1'b0;
            merge_we           = jmp;
         end
         OP_JC: begin
            jmp                = flags_in[FLAG_C];
            next_flags[FLAG_C] = 1'b0;
            merge_we           = jmp;
         end
         default: ;
      endcase
      // A not-taken jump leaves the register value untouched.
      if (!merge_we)
         next_flags = flags_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      flag_wdata = next_flags;
      flag_we    = merge_we;
      jmp_taken  = jmp;
      stall      = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      err_set    = 1'b0;
      case (state)
         IDLE: begin
            if (int_restore) begin
               state_nxt = RESTORE;
               err_set   = int_save;
            end else begin
               push = int_save;
            end
         end
         RESTORE: begin
            state_nxt  = IDLE;
            stall      = 1'b1;
            pop        = 1'b1;
            jmp_taken  = 1'b0;
            flag_we    = !stack_empty;
            flag_wdata = stack_empty ? flags_in : top_data;
         end
         default: state_nxt = IDLE;
      endcase
      // Outputs are combinational, so hold them quiet while reset is asserted.
      if (reset) begin
         flag_wdata = '0;
         flag_we    = 1'b0;
         jmp_taken  = 1'b0;
         stall      = 1'b0;
      end
   end

   flag_shadow_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .err_set   (err_set),
      .push_data (next_flags),
      .top_data  (top_data),
      .full      (stack_full),
      .empty     (stack_empty),
      .err       (stack_err)
   );

endmodule

// File: tb/tb_flag_ctrl_unit.sv
// Directed bench for flag_ctrl_unit: merge ops, jumps, save/restore, stack
// overflow/underflow and reset in the middle of a restore.
module tb_flag_ctrl_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] ex_op;
   logic [2:0] alu_flags, alu_mask, flags_in;
   logic       int_save, int_restore;
   logic [2:0] flag_wdata;
   logic       flag_we, jmp_taken, stall, stack_full, stack_empty, stack_err;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   always #5 clk = ~clk;

   flag_ctrl_unit #(.WIDTH(3), .DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .ex_op       (ex_op),
      .alu_flags   (alu_flags),
      .alu_mask    (alu_mask),
      .flags_in    (flags_in),
      .int_save    (int_save),
      .int_restore (int_restore),
      .flag_wdata  (flag_wdata),
      .flag_we     (flag_we),
      .jmp_taken   (jmp_taken),
      .stall       (stall),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .stack_err   (stack_err)
   );

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ex_op = 3'd0; alu_flags = 3'b000; alu_mask = 3'b000; flags_in = 3'b000;
      int_save = 1'b0; int_restore = 1'b0;
   endtask

   task automatic do_reset();
      next_cyc();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      flags_in = 3'b111;
      @(negedge clk);
      chk_cnt++; if (flag_we !== 1'b0) $display("FAIL reset_we got %b exp 0", flag_we); else pass_cnt++;
      chk_cnt++; if (stack_empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", stack_empty); else pass_cnt++;
      chk_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else pass_cnt++;
      chk_cnt++; if (stack_err !== 1'b0) $display("FAIL reset_err got %b exp 0", stack_err); else pass_cnt++;
      chk_cnt++; if (stack_full !== 1'b0) $display("FAIL reset_full got %b exp 0", stack_full); else pass_cnt++;
      reset = 1'b0;
   endtask

   task automatic test_merge();
      next_cyc();
      idle_inputs();
      ex_op = 3'd1; flags_in = 3'b000; alu_flags = 3'b101; alu_mask = 3'b011;
      @(negedge clk);
      chk_cnt++; if (flag_wdata !== 3'b001) $display("FAIL alu_wdata got %b exp 001", flag_wdata); else pass_cnt++;
      chk_cnt++; if (flag_we !== 1'b1) $display("FAIL alu_we got %b exp 1", flag_we); else pass_cnt++;
      next_cyc();
      ex_op = 3'd2; flags_in = 3'b001;
      @(negedge clk);
      chk_cnt++; if (flag_wdata !== 3'b101) $display("FAIL setc_wdata got %b exp 101", flag_wdata); else pass_cnt++;
      chk_cnt++; if (flag_we !== 1'b1) $display("FAIL setc_we got %b exp 1", flag_we); else pass_cnt++;
      next_cyc();
      ex_op = 3'd3; flags_in = 3'b111;
      @(negedge clk);
      chk_cnt++; if (flag_wdata !== 3'b011) $display("FAIL clrc_wdata got %b exp 011", flag_wdata); else pass_cnt++;
      next_cyc();
      ex_op = 3'd1; flags_in = 3'b010; alu_flags = 3'b101; alu_mask = 3'b000;
      @(negedge clk);
      chk_cnt++; if (flag_we !== 1'b0) $display("FAIL alu_nomask_we got %b exp 0", flag_we); else pass_cnt++;
      next_cyc();
      ex_op = 3'd7; flags_in = 3'b110;
      @(negedge clk);
      chk_cnt++; if ({flag_we, flag_wdata} !== 4'b0110) $display("FAIL rsvd got we=%b wd=%b exp we=0 wd=110", flag_we, flag_wdata); else pass_cnt++;
   endtask

   task automatic test_jumps();
      next_cyc();
      idle_inputs();
      ex_op = 3'd4; flags_in = 3'b001;
      @(negedge clk);
      chk_cnt++; if (jmp_taken !== 1'b1) $display("FAIL jz_taken got %b exp 1", jmp_taken); else pass_cnt++;
      chk_cnt++; if (flag_wdata !== 3'b000) $display("FAIL jz_wdata got %b exp 000", flag_wdata); else pass_cnt++;
      chk_cnt++; if (flag_we !== 1'b1) $display("FAIL jz_we got %b exp 1", flag_we); else pass_cnt++;
      next_cyc();
      ex_op = 3'd6; flags_in = 3'b001;
      @(negedge clk);
      chk_cnt++; if (jmp_taken !== 1'b0) $display("FAIL jc_taken got %b exp 0", jmp_taken); else pass_cnt++;
      chk_cnt++; if (flag_we !== 1'b0) $display("FAIL jc_we got %b exp 0", flag_we); else pass_cnt++;
      next_cyc();
      ex_op = 3'd5; flags_in = 3'b111;
      @(negedge clk);
      chk_cnt++; if ({jmp_taken, flag_we, flag_wdata} !== 5'b11101) $display("FAIL jn got jt=%b we=%b wd=%b exp 1 1 101", jmp_taken, flag_we, flag_wdata); else pass_cnt++;
   endtask

   task automatic test_save_restore();
      next_cyc();
      idle_inputs();
      ex_op = 3'd1; flags_in = 3'b000; alu_flags = 3'b110; alu_mask = 3'b111; int_save = 1'b1;
      @(negedge clk);
      chk_cnt++; if (flag_wdata !== 3'b110) $display("FAIL save_wdata got %b exp 110", flag_wdata); else pass_cnt++;
      next_cyc();
      idle_inputs();
      ex_op = 3'd3; flags_in = 3'b110;
      @(negedge clk);
      chk_cnt++; if ({stack_empty, flag_wdata} !== 4'b0010) $display("FAIL clobber got empty=%b wd=%b exp 0 010", stack_empty, flag_wdata); else pass_cnt++;
      next_cyc();
      ex_op = 3'd1; flags_in = 3'b010; alu_flags = 3'b001; alu_mask = 3'b001; int_restore = 1'b1;
      @(negedge clk);
      chk_cnt++; if ({flag_we, flag_wdata, stall} !== 5'b10110) $display("FAIL rti_cycle got we=%b wd=%b st=%b exp 1 011 0", flag_we, flag_wdata, stall); else pass_cnt++;
      next_cyc();
      idle_inputs();
      ex_op = 3'd4; flags_in = 3'b011;
      @(negedge clk);
      chk_cnt++; if (stall !== 1'b1) $display("FAIL restore_stall got %b exp 1", stall); else pass_cnt++;
      chk_cnt++; if ({flag_we, flag_wdata, jmp_taken} !== 5'b11100) $display("FAIL restore_write got we=%b wd=%b jt=%b exp 1 110 0", flag_we, flag_wdata, jmp_taken); else pass_cnt++;
      next_cyc();
      idle_inputs();
      @(negedge clk);
      chk_cnt++; if ({stall, stack_empty, stack_err} !== 3'b010) $display("FAIL after_restore got st=%b em=%b er=%b exp 0 1 0", stall, stack_empty, stack_err); else pass_cnt++;
   endtask

   task automatic test_overflow_underflow();
      logic [2:0] vals [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
      logic [2:0] pops [4] = '{3'b100, 3'b011, 3'b010, 3'b001};
      for (int i = 0; i < 5; i++) begin
         next_cyc();
         idle_inputs();
         ex_op = 3'd1; alu_flags = vals[i]; alu_mask = 3'b111; int_save = 1'b1;
         next_cyc();
         idle_inputs();
         if (i == 3) begin
            chk_cnt++; if ({stack_full, stack_err} !== 2'b10) $display("FAIL full4 got full=%b err=%b exp 1 0", stack_full, stack_err); else pass_cnt++;
         end
         if (i == 4) begin
            chk_cnt++; if ({stack_full, stack_err} !== 2'b11) $display("FAIL ovf5 got full=%b err=%b exp 1 1", stack_full, stack_err); else pass_cnt++;
         end
      end
      for (int i = 0; i < 5; i++) begin
         next_cyc();
         idle_inputs();
         int_restore = 1'b1;
         next_cyc();
         idle_inputs();
         flags_in = 3'b111;
         @(negedge clk);
         if (i < 4) begin
            chk_cnt++; if ({stall, flag_we, flag_wdata} !== {2'b11, pops[i]}) $display("FAIL pop%0d got st=%b we=%b wd=%b exp 1 1 %b", i, stall, flag_we, flag_wdata, pops[i]); else pass_cnt++;
         end else begin
            chk_cnt++; if ({stall, flag_we} !== 2'b10) $display("FAIL pop_empty got st=%b we=%b exp 1 0", stall, flag_we); else pass_cnt++;
         end
      end
      next_cyc();
      @(negedge clk);
      chk_cnt++; if ({stack_empty, stack_err} !== 2'b11) $display("FAIL unf_sticky got em=%b er=%b exp 1 1", stack_empty, stack_err); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      idle_inputs();
      @(negedge clk);
      chk_cnt++; if (stack_err !== 1'b0) $display("FAIL err_cleared got %b exp 0", stack_err); else pass_cnt++;
      next_cyc();
      ex_op = 3'd2; flags_in = 3'b000; int_save = 1'b1;
      next_cyc();
      idle_inputs();
      int_save = 1'b1; int_restore = 1'b1;
      next_cyc();
      idle_inputs();
      int_save = 1'b1;
      @(negedge clk);
      chk_cnt++; if ({stack_err, stall, flag_we, flag_wdata} !== 6'b111100) $display("FAIL both_req got er=%b st=%b we=%b wd=%b exp 1 1 1 100", stack_err, stall, flag_we, flag_wdata); else pass_cnt++;
      next_cyc();
      idle_inputs();
      @(negedge clk);
      chk_cnt++; if ({stack_empty, stall} !== 2'b10) $display("FAIL save_in_restore got em=%b st=%b exp 1 0", stack_empty, stall); else pass_cnt++;
   endtask

   task automatic test_reset_mid_restore();
      do_reset();
      idle_inputs();
      next_cyc();
      ex_op = 3'd1; alu_flags = 3'b111; alu_mask = 3'b111; int_save = 1'b1;
      next_cyc();
      idle_inputs();
      int_restore = 1'b1;
      next_cyc();
      idle_inputs();
      #1;
      chk_cnt++; if ({stall, flag_we} !== 2'b11) $display("FAIL pre_reset got st=%b we=%b exp 1 1", stall, flag_we); else pass_cnt++;
      #1;
      reset = 1'b1;
      #1;
      chk_cnt++; if ({stall, flag_we, stack_empty} !== 3'b001) $display("FAIL mid_reset got st=%b we=%b em=%b exp 0 0 1", stall, flag_we, stack_empty); else pass_cnt++;
      reset = 1'b0;
      #1;
      chk_cnt++; if ({stall, flag_we} !== 2'b00) $display("FAIL post_reset_idle got st=%b we=%b exp 0 0", stall, flag_we); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_merge();
      test_jumps();
      test_save_restore();
      test_overflow_underflow();
      test_back_to_back();
      test_reset_mid_restore();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
